countdown_arbiter: RTL

Shares one N-bit loadable down-counter among R requesters that each need a timed countdown of their own length. A round-robin arbiter picks a requester, loads its value, counts down to zero and returns a one-cycle done pulse to the owner. It sits above the existing counter blocks as the sequencing layer, so lab-level modules share a single timer instead of instantiating one each.

---
 rtl/countdown_pkg.sv | 35 +++
 rtl/countdown_arbiter_down_counter.sv | 25 ++
 rtl/countdown_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and the round-robin pick helper for the countdown arbiter.
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    localparam int RMAX = 4;
    localparam int IW   = 2;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] idx;
    } pick_t;

    // First set request at or above ptr, wrapping modulo nreq. Walking the
    // offsets downward lets the smallest offset win without an early exit.
    function automatic pick_t rr_pick(input logic [RMAX-1:0] req,
                                      input logic [IW-1:0]   ptr,
                                      input int              nreq);
        pick_t p;
        int    j;
        p = '0;
        for (int k = RMAX - 1; k >= 0; k--) begin
            if (k < nreq) begin
                j = int'(ptr) + k;
                if (j >= nreq) j = j - nreq;
                if (req[j[IW-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = j[IW-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/countdown_arbiter_down_counter.sv
// Loadable down-counter that saturates at zero; load wins over en.
module down_counter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         r,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (r)
            q <= '0;
        else if (load)
            q <= d;
        else if (en && (q != '0))
            q <= q - 1'b1;
    end

    assign zero = (q == '0);

endmodule

// File: rtl/countdown_arbiter.sv
// Round-robin sharing of one down-counter among R requesters.
//
//   state | meaning
//   IDLE  | waiting for any req; picks owner from ptr upward
//   LOAD  | counter loads the value latched at grant
//   COUNT | decrementing (held by pause) until the counter reads zero
//   DONE  | done pulse to owner, rotate ptr, release grant
module countdown_arbiter
    import countdown_pkg::*;
#(
    parameter int N = 6,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           r,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] val,
    input  logic           pause,
    input  logic           abort,
    output logic [R-1:0]   grant,
    output logic           busy,
    output logic [N-1:0]   out,
    output logic [R-1:0]   done
);

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_next;
    logic [N-1:0]   lval;
    logic [RMAX-1:0] req_pad;
    pick_t          pk;
    logic           cnt_load;
    logic           cnt_en;
    logic [N-1:0]   cnt_d;
    logic           cnt_zero;

    always_comb begin
        req_pad        = '0;
        req_pad[R-1:0] = req;
        pk             = rr_pick(req_pad, ptr, R);
        idx_next       = (idx == IW'(R - 1)) ? '0 : idx + 1'b1;
    end

    // Abort reuses the load path with a zero operand so out reads 0 in IDLE.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_d    = lval;
        case (state)
            LOAD: begin
                cnt_load = 1'b1;
                if (abort) cnt_d = '0;
            end
            COUNT: begin
                if (abort) begin
                    cnt_load = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_en = !pause;
                end
            end
            default: ;
        endcase
    end

    down_counter #(.N(N)) u_cnt (
        .clk  (clk),
        .r    (r),
        .load (cnt_load),
        .en   (cnt_en),
        .d    (cnt_d),
        .q    (out),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
            ptr   <= '0;
            idx   <= '0;
            lval  <= '0;
            grant <= '0;
            busy  <= 1'b0;
            done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (pk.found) begin
                        idx   <= pk.idx;
                        lval  <= val[int'(pk.idx)*N +: N];
                        grant <= R'(1) << pk.idx;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= idx_next;
                        state <= IDLE;
                    end else begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= idx_next;
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        done  <= grant;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= idx_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
